// File: rtl/sniffer_replay_src.sv
// Packet replay source: CSR-loaded packet buffer and rule bank, replayed as an
// Avalon-ST stream with backpressure, repeat count and inter-packet gap.
module sniffer_replay_src #(
  parameter int DATAWIDTH          = 32,
  parameter int SLAVE_ADDRESSWIDTH = 4,
  parameter int BUF_DEPTH          = 256,
  parameter int NUMRULES           = 4,
  localparam int BPB = DATAWIDTH / 8,
  localparam int EW  = (BPB > 1) ? $clog2(BPB) : 1,
  localparam int AW  = $clog2(BUF_DEPTH)
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]    slave_address,
  input  logic [DATAWIDTH-1:0]             slave_writedata,
  input  logic                             slave_write,
  input  logic                             slave_read,
  input  logic                             slave_chipselect,
  output logic [DATAWIDTH-1:0]             slave_readdata,
  output logic [DATAWIDTH-1:0]             src_data,
  output logic                             src_valid,
  output logic                             src_sop,
  output logic                             src_eop,
  output logic [EW-1:0]                    src_empty,
  input  logic                             src_ready,
  output logic [NUMRULES*DATAWIDTH-1:0]    rules_out
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_CTRL     = SLAVE_ADDRESSWIDTH'(0);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STATUS   = SLAVE_ADDRESSWIDTH'(1);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_PKT_LEN  = SLAVE_ADDRESSWIDTH'(2);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_BUF_PTR  = SLAVE_ADDRESSWIDTH'(3);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_BUF_DATA = SLAVE_ADDRESSWIDTH'(4);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_REPEAT   = SLAVE_ADDRESSWIDTH'(5);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_GAP      = SLAVE_ADDRESSWIDTH'(6);

  state_t               state;
  logic [AW-1:0]        idx, last_idx, buf_ptr;
  logic [EW-1:0]        last_empty;
  logic [15:0]          pkt_len, rpt, gap_len, gap_cnt, pkts_sent;
  logic                 infinite, done, len_err, rule_err, stop_pending;
  logic [DATAWIDTH-1:0] mem   [BUF_DEPTH];
  logic [DATAWIDTH-1:0] rules [NUMRULES];
  logic [DATAWIDTH-1:0] rd_mux;

  logic          wr_en, busy, ctrl_wr, start_cmd, stop_cmd, len_ok, xfer;
  logic          finish_now, launch;
  logic [AW-1:0] start_last, first_last, idx_nxt;
  logic [EW-1:0] start_empty, first_empty;
  logic [15:0]   pkts_inc, rpt_target;

  assign wr_en     = slave_chipselect & slave_write;
  assign busy      = (state != IDLE);
  assign ctrl_wr   = wr_en && (slave_address == A_CTRL);
  assign start_cmd = ctrl_wr & slave_writedata[0] & ~slave_writedata[1];
  assign stop_cmd  = ctrl_wr & slave_writedata[1];
  assign xfer      = src_valid & src_ready;
  assign idx_nxt   = idx + 1'b1;

  assign len_ok      = (pkt_len != 16'd0) && (32'(pkt_len) <= 32'(BUF_DEPTH * BPB));
  assign start_last  = AW'((32'(pkt_len) - 32'd1) / 32'(BPB));
  assign start_empty = EW'((32'(BPB) - (32'(pkt_len) % 32'(BPB))) % 32'(BPB));
  // The first beat of a repeat uses the geometry latched at start, not live CSRs.
  assign first_last  = busy ? last_idx : start_last;
  assign first_empty = busy ? last_empty : start_empty;

  assign pkts_inc   = (pkts_sent == 16'hFFFF) ? pkts_sent : pkts_sent + 16'd1;
  assign rpt_target = (rpt == 16'd0) ? 16'd1 : rpt;
  assign finish_now = (!infinite && (pkts_inc >= rpt_target)) || stop_pending || stop_cmd;

  assign launch = (state == IDLE && start_cmd && len_ok) ||
                  (state == SEND && xfer && src_eop && !finish_now && gap_len == 16'd0) ||
                  (state == GAP && !stop_cmd && !stop_pending && gap_cnt == 16'd0);

  // NOTE: the packet buffer is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en && slave_address == A_BUF_DATA && !busy)
      mem[buf_ptr] <= slave_writedata;
  end

  // NOTE: all state here uses non-blocking assignment so every read sees pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      infinite     <= 1'b0;
      pkt_len      <= '0;
      buf_ptr      <= '0;
      rpt          <= '0;
      gap_len      <= '0;
      gap_cnt      <= '0;
      pkts_sent    <= '0;
      done         <= 1'b0;
      len_err      <= 1'b0;
      rule_err     <= 1'b0;
      stop_pending <= 1'b0;
      last_idx     <= '0;
      last_empty   <= '0;
      for (int i = 0; i < NUMRULES; i++) rules[i] <= '0;
    end else begin
      if (wr_en) begin
        case (slave_address)
          A_CTRL:     infinite <= slave_writedata[2];
          A_PKT_LEN:  pkt_len  <= slave_writedata[15:0];
          A_BUF_PTR:  buf_ptr  <= slave_writedata[AW-1:0];
          A_BUF_DATA: if (!busy) buf_ptr <= buf_ptr + 1'b1;
          A_REPEAT:   rpt      <= slave_writedata[15:0];
          A_GAP:      gap_len  <= slave_writedata[15:0];
          default:    ;
        endcase
      end
      for (int i = 0; i < NUMRULES; i++) begin
        if (wr_en && slave_address == SLAVE_ADDRESSWIDTH'(8 + i)) begin
          if (busy) rule_err <= 1'b1;
          else      rules[i] <= slave_writedata;
        end
      end

      case (state)
        IDLE: begin
          if (start_cmd) begin
            if (len_ok) begin
              state        <= SEND;
              done         <= 1'b0;
              len_err      <= 1'b0;
              rule_err     <= 1'b0;
              pkts_sent    <= '0;
              stop_pending <= 1'b0;
              last_idx     <= start_last;
              last_empty   <= start_empty;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (stop_cmd) stop_pending <= 1'b1;
          if (xfer && src_eop) begin
            pkts_sent <= pkts_inc;
            if (finish_now) begin
              state        <= IDLE;
              done         <= 1'b1;
              stop_pending <= 1'b0;
            end else if (gap_len != 16'd0) begin
              state   <= GAP;
              gap_cnt <= gap_len - 16'd1;
            end
          end
        end
        GAP: begin
          if (stop_cmd || stop_pending) begin
            state        <= IDLE;
            done         <= 1'b1;
            stop_pending <= 1'b0;
          end else if (gap_cnt == 16'd0) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stream datapath: beat fields only change on launch or on an accepted beat.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx       <= '0;
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      src_empty <= '0;
      src_data  <= '0;
    end else if (launch) begin
      idx       <= '0;
      src_valid <= 1'b1;
      src_sop   <= 1'b1;
      src_eop   <= (first_last == '0);
      src_empty <= (first_last == '0) ? first_empty : '0;
      src_data  <= mem[0];
    end else if (xfer) begin
      if (src_eop) begin
        src_valid <= 1'b0;
        src_sop   <= 1'b0;
        src_eop   <= 1'b0;
        src_empty <= '0;
      end else begin
        idx       <= idx_nxt;
        src_sop   <= 1'b0;
        src_eop   <= (idx_nxt == last_idx);
        src_empty <= (idx_nxt == last_idx) ? last_empty : '0;
        src_data  <= mem[idx_nxt];
      end
    end
  end

  // NOTE: rd_mux gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_mux = '0;
    case (slave_address)
      A_CTRL:     rd_mux[2] = infinite;
      A_STATUS:   rd_mux = DATAWIDTH'({pkts_sent, 12'd0, rule_err, len_err, done, busy});
      A_PKT_LEN:  rd_mux = DATAWIDTH'(pkt_len);
      A_BUF_PTR:  rd_mux = DATAWIDTH'(buf_ptr);
      A_BUF_DATA: rd_mux = mem[buf_ptr];
      A_REPEAT:   rd_mux = DATAWIDTH'(rpt);
      A_GAP:      rd_mux = DATAWIDTH'(gap_len);
      default:    ;
    endcase
    for (int i = 0; i < NUMRULES; i++)
      if (slave_address == SLAVE_ADDRESSWIDTH'(8 + i)) rd_mux = rules[i];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                               slave_readdata <= '0;
    else if (slave_chipselect && slave_read)  slave_readdata <= rd_mux;
  end

  for (genvar g = 0; g < NUMRULES; g++) begin : g_rules
    assign rules_out[g*DATAWIDTH +: DATAWIDTH] = rules[g];
  end

endmodule

// File: tb/tb_sniffer_replay_src.sv
// Directed bench for sniffer_replay_src: CSR vector table plus stream sequences.
module tb_sniffer_replay_src;
  localparam int DW = 32;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [3:0]    slave_address = '0;
  logic [DW-1:0] slave_writedata = '0;
  logic          slave_write = 1'b0, slave_read = 1'b0, slave_chipselect = 1'b0;
  logic [DW-1:0] slave_readdata, src_data;
  logic          src_valid, src_sop, src_eop;
  logic [1:0]    src_empty;
  logic          src_ready = 1'b0;
  logic [NR*DW-1:0] rules_out;

  sniffer_replay_src dut (
    .clk(clk), .n_rst(n_rst),
    .slave_address(slave_address), .slave_writedata(slave_writedata),
    .slave_write(slave_write), .slave_read(slave_read),
    .slave_chipselect(slave_chipselect), .slave_readdata(slave_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop),
    .src_eop(src_eop), .src_empty(src_empty), .src_ready(src_ready),
    .rules_out(rules_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic csr_wr(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    slave_address = addr; slave_writedata = data;
    slave_chipselect = 1'b1; slave_write = 1'b1;
    @(negedge clk);
    slave_chipselect = 1'b0; slave_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    slave_address = addr; slave_chipselect = 1'b1; slave_read = 1'b1;
    @(negedge clk);
    slave_chipselect = 1'b0; slave_read = 1'b0;
    data = slave_readdata;
  endtask

  task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] expected);
    logic [31:0] d;
    csr_rd(addr, d);
    check(name, d, expected);
  endtask

  logic [31:0] got_data[$];
  logic        got_sop[$];
  logic        got_eop[$];
  logic [1:0]  got_empty[$];
  int          got_gap[$];

  // Records accepted beats until n_eops eop transfers; mode 1 toggles ready.
  task automatic collect(input int n_eops, input int mode, input int budget);
    int eops = 0, idle = 0, cyc = 0;
    bit started = 0, held = 0;
    logic [36:0] held_v;
    got_data.delete(); got_sop.delete(); got_eop.delete();
    got_empty.delete(); got_gap.delete();
    while (eops < n_eops && cyc < budget) begin
      src_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (held) begin
        check("stall_hold", {src_valid, src_data, src_sop, src_eop, src_empty}, held_v);
        held = 0;
      end
      if (src_valid && src_ready) begin
        if (src_sop && started) got_gap.push_back(idle);
        idle = 0; started = 1;
        got_data.push_back(src_data); got_sop.push_back(src_sop);
        got_eop.push_back(src_eop);   got_empty.push_back(src_empty);
        if (src_eop) eops++;
      end else if (src_valid) begin
        held = 1;
        held_v = {src_valid, src_data, src_sop, src_eop, src_empty};
      end else begin
        idle++;
      end
      cyc++;
      @(negedge clk);
    end
    if (eops < n_eops) check("collect_timeout", 64'(eops), 64'(n_eops));
  endtask

  // Beat k carries word (first_w+k)%nw, whose value is 0x11111111*(word+1).
  task automatic check_beats(input string tag, input int first_w, input int nw,
                             input int total, input int el);
    check({tag, "_count"}, 64'(got_data.size()), 64'(total));
    for (int k = 0; k < total && k < got_data.size(); k++) begin
      int w;
      logic [31:0] ed;
      logic        es, ee;
      logic [1:0]  em;
      w  = (first_w + k) % nw;
      ed = 32'h11111111 * 32'(w + 1);
      es = (w == 0);
      ee = (w == nw - 1);
      em = ee ? 2'(el) : 2'd0;
      check($sformatf("%s_beat%0d", tag, k),
            {got_data[k], got_sop[k], got_eop[k], got_empty[k]}, {ed, es, ee, em});
    end
  endtask

  task automatic check_gaps(input string tag, input int n, input int g);
    check({tag, "_gap_count"}, 64'(got_gap.size()), 64'(n));
    for (int k = 0; k < got_gap.size(); k++)
      check($sformatf("%s_gap%0d", tag, k), 64'(got_gap[k]), 64'(g));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int cyc = 0;
    while (src_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_idle"}, 64'(src_valid), 64'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } csr_vec_t;

  csr_vec_t vecs[15];

  initial begin
    int cyc, xfers, hits;
    vecs[0]  = '{1'b0, 4'd0,  32'h0,        4'd1,  32'h0};
    vecs[1]  = '{1'b1, 4'd2,  32'hABCD000E, 4'd2,  32'h0000000E};
    vecs[2]  = '{1'b1, 4'd5,  32'hFFFF0003, 4'd5,  32'h00000003};
    vecs[3]  = '{1'b1, 4'd6,  32'h00010007, 4'd6,  32'h00000007};
    vecs[4]  = '{1'b1, 4'd3,  32'h000001FF, 4'd3,  32'h000000FF};
    vecs[5]  = '{1'b1, 4'd0,  32'h00000004, 4'd0,  32'h00000004};
    vecs[6]  = '{1'b1, 4'd0,  32'h00000000, 4'd0,  32'h00000000};
    vecs[7]  = '{1'b1, 4'd7,  32'hDEADBEEF, 4'd7,  32'h00000000};
    vecs[8]  = '{1'b1, 4'd12, 32'hDEADBEEF, 4'd12, 32'h00000000};
    vecs[9]  = '{1'b1, 4'd9,  32'h12345678, 4'd9,  32'h12345678};
    vecs[10] = '{1'b1, 4'd11, 32'hCAFEF00D, 4'd11, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 4'd3,  32'h00000010, 4'd3,  32'h00000010};
    vecs[12] = '{1'b1, 4'd4,  32'hA5A5A5A5, 4'd3,  32'h00000011};
    vecs[13] = '{1'b1, 4'd3,  32'h00000010, 4'd4,  32'hA5A5A5A5};
    vecs[14] = '{1'b0, 4'd0,  32'h0,        4'd8,  32'h00000000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stream", {src_valid, src_sop, src_eop, src_empty, src_data}, 64'd0);
    check("rst_readdata", slave_readdata, 64'd0);
    check("rst_rules_lo", rules_out[63:0], 64'd0);
    check("rst_rules_hi", rules_out[127:64], 64'd0);
    n_rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) csr_wr(vecs[i].waddr, vecs[i].wdata);
      rd_check($sformatf("csr_vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Single 14-byte packet
    csr_wr(3, 0);
    for (int i = 1; i <= 4; i++) csr_wr(4, 32'h11111111 * 32'(i));
    csr_wr(2, 14); csr_wr(5, 1); csr_wr(6, 0);
    src_ready = 1'b1;
    csr_wr(0, 1);
    check("first_beat", {src_valid, src_sop, src_data}, {1'b1, 1'b1, 32'h11111111});
    collect(1, 0, 50);
    check_beats("single", 0, 4, 4, 2);
    check("single_valid_after", 64'(src_valid), 64'd0);
    rd_check("single_status", 1, 32'h00010002);

    // One-byte packet repeated back to back
    csr_wr(2, 1); csr_wr(5, 2);
    csr_wr(0, 1);
    collect(2, 0, 50);
    check_beats("len1", 0, 1, 2, 3);
    check_gaps("len1", 1, 0);
    rd_check("len1_status", 1, 32'h00020002);

    // Three packets with a 5-cycle gap
    csr_wr(2, 14); csr_wr(5, 3); csr_wr(6, 5);
    csr_wr(0, 1);
    collect(3, 0, 200);
    check_beats("rep3", 0, 4, 12, 2);
    check_gaps("rep3", 2, 5);
    rd_check("rep3_status", 1, 32'h00030002);

    // Random backpressure
    csr_wr(5, 1); csr_wr(6, 0);
    csr_wr(0, 1);
    collect(1, 1, 300);
    check_beats("rand", 0, 4, 4, 2);
    rd_check("rand_status", 1, 32'h00010002);

    // Infinite mode, graceful stop during beat 1 of packet 2
    src_ready = 1'b1;
    csr_wr(0, 32'h5);
    xfers = 0; cyc = 0;
    while (xfers < 5 && cyc < 50) begin
      if (src_valid && src_ready) xfers++;
      @(negedge clk);
      cyc++;
    end
    src_ready = 1'b0;
    check("inf_beat1", {src_valid, src_sop, src_data}, {1'b1, 1'b0, 32'h22222222});
    csr_wr(0, 32'h6);
    check("inf_stall_hold", {src_valid, src_data}, {1'b1, 32'h22222222});
    collect(1, 0, 50);
    check_beats("inf_tail", 1, 4, 3, 2);
    check("inf_valid_after", 64'(src_valid), 64'd0);
    rd_check("inf_status", 1, 32'h00020002);
    csr_wr(0, 32'h3);
    check("start_stop_no_launch", 64'(src_valid), 64'd0);
    rd_check("start_stop_status", 1, 32'h00020002);

    // Stop while in GAP
    csr_wr(5, 3); csr_wr(6, 5);
    src_ready = 1'b1;
    csr_wr(0, 1);
    cyc = 0;
    while (!(src_valid && src_ready && src_eop) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("gapstop_eop_seen", 64'(src_valid & src_eop), 64'd1);
    csr_wr(0, 2);
    rd_check("gapstop_status", 1, 32'h00010002);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (src_valid) hits++;
      @(negedge clk);
    end
    check("gapstop_no_beats", 64'(hits), 64'd0);

    // Length bounds
    csr_wr(2, 0);
    csr_wr(0, 1);
    check("len0_no_valid", 64'(src_valid), 64'd0);
    rd_check("len0_status", 1, 32'h00010006);
    csr_wr(2, 1024);
    csr_wr(0, 1);
    rd_check("lenmax_busy", 1, 32'h00000001);
    csr_wr(0, 2);
    wait_idle("lenmax", 600);
    rd_check("lenmax_status", 1, 32'h00010002);
    csr_wr(2, 1025);
    csr_wr(0, 1);
    check("lenover_no_valid", 64'(src_valid), 64'd0);
    rd_check("lenover_status", 1, 32'h00010006);

    // Rules: idle write lands, busy write dropped
    csr_wr(8, 32'hC0A80001);
    check("rule0_out", rules_out[31:0], 64'hC0A80001);
    csr_wr(2, 14); csr_wr(5, 1); csr_wr(6, 0);
    src_ready = 1'b0;
    csr_wr(0, 1);
    rd_check("rule_busy_status", 1, 32'h00000001);
    csr_wr(9, 32'hDEAD0001);
    check("rule1_out_kept", rules_out[63:32], 64'h12345678);
    rd_check("rule1_rd_kept", 9, 32'h12345678);
    rd_check("rule_err_status", 1, 32'h00000009);
    src_ready = 1'b1;
    wait_idle("rule", 50);
    rd_check("rule_done_status", 1, 32'h0001000A);
    src_ready = 1'b0;
    csr_wr(0, 1);
    rd_check("rule_err_cleared", 1, 32'h00000001);
    src_ready = 1'b1;
    wait_idle("rule2", 50);

    // Reset mid-packet
    csr_wr(5, 3);
    csr_wr(0, 1);
    @(negedge clk);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("arst_stream", {src_valid, src_sop, src_eop, src_empty, src_data}, 64'd0);
    check("arst_readdata", slave_readdata, 64'd0);
    check("arst_rules_lo", rules_out[63:0], 64'd0);
    check("arst_rules_hi", rules_out[127:64], 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    rd_check("arst_status", 1, 32'h0);
    rd_check("arst_pkt_len", 2, 32'h0);
    rd_check("arst_rule0", 8, 32'h0);
    check("arst_valid_after", 64'(src_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
